// File: rtl/slave_port_pkg.sv
// slave_port_pkg: FSM state encoding and default widths shared by the ADS serial slave port
package slave_port_pkg;
  localparam int DEF_ADDR_WIDTH = 12;
  localparam int DEF_DATA_WIDTH = 8;
  typedef enum logic [2:0] {IDLE, ADDR, WDATA, MEMW, MEMR, SPLIT, GRANT, RDATA} state_t;
endpackage

// File: rtl/slave_port.sv
// slave_port: ADS serial slave; swdata/smode/mvalid in LSB-first -> smemaddr/smemwdata/smemwen/smemren to memory, smemrdata/smemrvalid -> srdata/svalid out, ssplit/split_grant split handshake, sready idle
module slave_port
  import slave_port_pkg::*;
#(
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int SPLIT_EN = 0
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic                  swdata,
  input  logic                  smode,
  input  logic                  mvalid,
  output logic                  srdata,
  output logic                  svalid,
  output logic                  sready,
  output logic                  ssplit,
  input  logic                  split_grant,
  output logic [ADDR_WIDTH-1:0] smemaddr,
  output logic [DATA_WIDTH-1:0] smemwdata,
  output logic                  smemwen,
  output logic                  smemren,
  input  logic [DATA_WIDTH-1:0] smemrdata,
  input  logic                  smemrvalid
);
  localparam int CW = $clog2(ADDR_WIDTH > DATA_WIDTH ? ADDR_WIDTH : DATA_WIDTH);
  state_t state, nxt;
  logic [CW-1:0] cnt;
  logic mode, alast, dlast, step;
  logic [ADDR_WIDTH-1:0] ash;
  logic [DATA_WIDTH-1:0] wsh, rdata;
  assign sready = state == IDLE;
  assign alast = cnt == CW'(ADDR_WIDTH - 1);
  assign dlast = cnt == CW'(DATA_WIDTH - 1);
  assign step = (mvalid && state inside {IDLE, ADDR, WDATA}) || nxt == RDATA;
  always_comb begin
    nxt = state;
    case (state)
      IDLE:    nxt = mvalid ? ADDR : IDLE;
      ADDR:    nxt = mvalid && alast ? (mode ? WDATA : MEMR) : ADDR;
      WDATA:   nxt = mvalid && dlast ? MEMW : WDATA;
      MEMW:    nxt = IDLE;
      MEMR:    nxt = SPLIT_EN != 0 ? SPLIT : smemrvalid ? RDATA : MEMR;
      SPLIT:   nxt = smemrvalid ? GRANT : SPLIT;
      GRANT:   nxt = split_grant ? RDATA : GRANT;
      RDATA:   nxt = cnt == '0 ? IDLE : RDATA;
      default: nxt = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) state <= IDLE;
    else state <= nxt;
  end
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      cnt       <= '0;
      mode      <= 1'b0;
      ash       <= '0;
      wsh       <= '0;
      rdata     <= '0;
      smemaddr  <= '0;
      smemwdata <= '0;
      smemwen   <= 1'b0;
      smemren   <= 1'b0;
      ssplit    <= 1'b0;
      svalid    <= 1'b0;
      srdata    <= 1'b0;
    end else begin
      smemwen <= state == WDATA && nxt == MEMW;
      smemren <= state == ADDR && nxt == MEMR;
      ssplit  <= nxt == SPLIT;
      svalid  <= nxt == RDATA;
      srdata  <= nxt != RDATA ? 1'b0 : state == MEMR ? smemrdata[0] : rdata[0];
      if (step) cnt <= (state inside {ADDR, WDATA} && nxt != state) || (state == RDATA && dlast) ? '0 : cnt + 1'b1;
      if (state == IDLE && mvalid) mode <= smode;
      if (state inside {IDLE, ADDR} && mvalid) ash <= {swdata, ash[ADDR_WIDTH-1:1]};
      if (state == ADDR && nxt != ADDR) smemaddr <= {swdata, ash[ADDR_WIDTH-1:1]};
      if (state == WDATA && mvalid) wsh <= {swdata, wsh[DATA_WIDTH-1:1]};
      if (state == WDATA && nxt == MEMW) smemwdata <= {swdata, wsh[DATA_WIDTH-1:1]};
      if (smemrvalid && state inside {MEMR, SPLIT}) rdata <= nxt == RDATA ? smemrdata >> 1 : smemrdata;
      else if (nxt == RDATA) rdata <= rdata >> 1;
    end
  end
endmodule

// File: tb/tb_slave_port.sv
// tb_slave_port: randomized master/memory environment checking two slave_port instances (no split, split) against a timestamp model
module tb_slave_port;
  localparam int AW = 12;
  localparam int DW = 8;
  localparam int INF = 1 << 30;
  logic clk = 0, rstn = 0, swdata = 0, smode = 0, mvalid = 0;
  logic [1:0] srdata, svalid, sready, ssplit, sgnt, mwen, mren, mrv;
  logic [AW-1:0] maddr [2];
  logic [DW-1:0] mwd [2], mrd [2];
  logic [DW-1:0] refm [4096];
  logic [DW-1:0] mem [2][4096];
  logic [DW-1:0] rx [2];
  logic [AW-1:0] t_addr, exp_ma = '0;
  logic [DW-1:0] t_data, exp_wd = '0, pre;
  bit t_wr = 0;
  int checks = 0, errors = 0, ec = 0, lat_fix = 0;
  int F = INF, A = INF, N = INF;
  int E [2] = '{0, 0};
  int V [2] = '{INF, INF};
  int G [2] = '{INF, INF};
  int wt [2] = '{0, 0};
  always #5 clk = ~clk;
  always @(posedge clk) ec <= ec + 1;
  slave_port #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .SPLIT_EN(0)) u0 (
    .clk(clk), .rstn(rstn), .swdata(swdata), .smode(smode), .mvalid(mvalid),
    .srdata(srdata[0]), .svalid(svalid[0]), .sready(sready[0]), .ssplit(ssplit[0]),
    .split_grant(sgnt[0]), .smemaddr(maddr[0]), .smemwdata(mwd[0]), .smemwen(mwen[0]),
    .smemren(mren[0]), .smemrdata(mrd[0]), .smemrvalid(mrv[0]));
  slave_port #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .SPLIT_EN(1)) u1 (
    .clk(clk), .rstn(rstn), .swdata(swdata), .smode(smode), .mvalid(mvalid),
    .srdata(srdata[1]), .svalid(svalid[1]), .sready(sready[1]), .ssplit(ssplit[1]),
    .split_grant(sgnt[1]), .smemaddr(maddr[1]), .smemwdata(mwd[1]), .smemwen(mwen[1]),
    .smemren(mren[1]), .smemrdata(mrd[1]), .smemrvalid(mrv[1]));
  task automatic chk(input string nm, input int i, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s[%0d] got %h want %h at cycle %0d", nm, i, act, exp, ec);
    end
  endtask
  always @(negedge clk) begin
    int c;
    c = ec;
    if (!rstn) begin
      for (int i = 0; i < 2; i++) begin
        chk("rst_sready", i, 32'(sready[i]), 1);
        chk("rst_svalid", i, 32'(svalid[i]), 0);
        chk("rst_srdata", i, 32'(srdata[i]), 0);
        chk("rst_ssplit", i, 32'(ssplit[i]), 0);
        chk("rst_wen", i, 32'(mwen[i]), 0);
        chk("rst_ren", i, 32'(mren[i]), 0);
        chk("rst_addr", i, 32'(maddr[i]), 0);
        chk("rst_wdata", i, 32'(mwd[i]), 0);
      end
    end else begin
      if (c == A) exp_ma = t_addr;
      if (c == N) exp_wd = t_data;
      for (int i = 0; i < 2; i++) begin
        int s;
        bit sv;
        s = i == 1 ? G[i] : V[i];
        sv = !t_wr && c >= s && c < s + DW;
        chk("sready", i, 32'(sready[i]), 32'(!(c >= F && c < E[i])));
        chk("smemwen", i, 32'(mwen[i]), 32'(t_wr && c == N));
        chk("smemren", i, 32'(mren[i]), 32'(!t_wr && c == A));
        chk("ssplit", i, 32'(ssplit[i]), 32'(i == 1 && !t_wr && c > A && c < V[i]));
        chk("svalid", i, 32'(svalid[i]), 32'(sv));
        if (sv) begin
          chk("srdata", i, 32'(srdata[i]), 32'(refm[t_addr][c - s]));
          rx[i][c - s] = srdata[i];
        end
        chk("smemaddr", i, 32'(maddr[i]), 32'(exp_ma));
        chk("smemwdata", i, 32'(mwd[i]), 32'(exp_wd));
        if (mwen[i]) mem[i][maddr[i]] = mwd[i];
      end
    end
    for (int i = 0; i < 2; i++) begin
      mrv[i] = 1'b0;
      mrd[i] = DW'($urandom);
      if (!rstn) wt[i] = 0;
      else if (wt[i] > 0) begin
        wt[i]--;
        if (wt[i] == 0) begin
          mrv[i] = 1'b1;
          mrd[i] = mem[i][maddr[i]];
          V[i] = c + 1;
          if (i == 0) E[0] = V[0] + DW;
        end
      end else if (mren[i]) wt[i] = lat_fix != 0 ? lat_fix : $urandom_range(1, 12);
      else if ($urandom_range(0, 7) == 0) mrv[i] = 1'b1;
    end
    sgnt[0] = 1'($urandom);
    sgnt[1] = 1'b0;
    if (rstn && !t_wr && c >= V[1] && G[1] == INF && $urandom_range(0, 2) == 0) begin
      sgnt[1] = 1'b1;
      G[1] = c + 1;
      E[1] = G[1] + DW;
    end else if (c < V[1]) sgnt[1] = 1'($urandom);
  end
  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      mvalid = 1'b0;
      swdata = 1'($urandom);
      smode = 1'($urandom);
    end
  endtask
  task automatic xfer(input bit wr, input logic [AW-1:0] a, input logic [DW-1:0] d, input int gmax, input int pgap, input bit drop3, input int abort);
    int w;
    for (int k = 0; k < AW; k++) begin
      idle(drop3 && k == 5 ? 3 : $urandom_range(0, gmax));
      @(negedge clk);
      mvalid = 1'b1;
      swdata = a[k];
      smode = k == 0 ? wr : 1'($urandom);
      if (k == 0) begin
        t_wr = wr;
        t_addr = a;
        t_data = d;
        F = ec + 1;
        A = INF;
        N = INF;
        for (int i = 0; i < 2; i++) begin
          E[i] = INF;
          V[i] = INF;
          G[i] = INF;
        end
      end
      if (k == AW - 1) A = ec + 1;
    end
    if (wr) begin
      idle(pgap);
      for (int k = 0; k < DW; k++) begin
        if (k == abort) begin
          @(negedge clk);
          mvalid = 1'b0;
          @(posedge clk);
          #2;
          rstn = 1'b0;
          F = INF;
          A = INF;
          N = INF;
          exp_ma = '0;
          exp_wd = '0;
          for (int i = 0; i < 2; i++) begin
            E[i] = 0;
            V[i] = INF;
            G[i] = INF;
          end
          repeat (3) @(posedge clk);
          #2;
          rstn = 1'b1;
          idle(2);
          return;
        end
        idle(drop3 && k == 3 ? 3 : $urandom_range(0, gmax));
        @(negedge clk);
        mvalid = 1'b1;
        swdata = d[k];
        smode = 1'($urandom);
        if (k == DW - 1) begin
          N = ec + 1;
          E[0] = N + 1;
          E[1] = N + 1;
          refm[a] = d;
        end
      end
    end
    w = 0;
    while (!(E[0] != INF && E[1] != INF && ec >= E[0] && ec >= E[1]) && w < 400) begin
      idle(1);
      w++;
    end
    if (w >= 400) begin
      checks++;
      errors++;
      $display("FAIL timeout addr %h got no completion want done within 400 cycles", a);
    end
    idle($urandom_range(0, 2));
  endtask
  initial begin
    #2000000;
    $display("FAIL watchdog got no finish want finish");
    $fatal(1);
  end
  initial begin
    for (int a = 0; a < 4096; a++) begin
      refm[a] = DW'($urandom);
      mem[0][a] = refm[a];
      mem[1][a] = refm[a];
    end
    refm[12'h0FF] = 8'h3D;
    mem[0][12'h0FF] = 8'h3D;
    mem[1][12'h0FF] = 8'h3D;
    refm[12'h2C7] = 8'hA5;
    mem[0][12'h2C7] = 8'hA5;
    mem[1][12'h2C7] = 8'hA5;
    sgnt = '0;
    mrv = '0;
    repeat (3) @(negedge clk);
    @(posedge clk);
    #2;
    rstn = 1'b1;
    idle(2);
    xfer(1, 12'h5A3, 8'hC6, 0, 1, 0, -1);
    chk("mem5A3", 0, 32'(mem[0][12'h5A3]), 32'h C6);
    chk("mem5A3", 1, 32'(mem[1][12'h5A3]), 32'h C6);
    lat_fix = 3;
    xfer(0, 12'h0FF, 8'h00, 0, 0, 0, -1);
    chk("rx0FF", 0, 32'(rx[0]), 32'h3D);
    chk("rx0FF", 1, 32'(rx[1]), 32'h3D);
    lat_fix = 10;
    xfer(0, 12'h2C7, 8'h00, 0, 0, 0, -1);
    chk("rx2C7", 0, 32'(rx[0]), 32'hA5);
    chk("rx2C7", 1, 32'(rx[1]), 32'hA5);
    xfer(1, 12'h5A3, 8'h96, 0, 1, 1, -1);
    chk("drop3", 0, 32'(mem[0][12'h5A3]), 32'h96);
    chk("drop3", 1, 32'(mem[1][12'h5A3]), 32'h96);
    pre = mem[0][12'h7E4];
    xfer(1, 12'h7E4, 8'h5B, 0, 1, 0, 4);
    chk("abort", 0, 32'(mem[0][12'h7E4]), 32'(pre));
    xfer(1, 12'h001, 8'h11, 0, 1, 0, -1);
    chk("mem001", 0, 32'(mem[0][12'h001]), 32'h11);
    chk("mem001", 1, 32'(mem[1][12'h001]), 32'h11);
    lat_fix = 0;
    for (int n = 0; n < 60; n++) begin
      bit w;
      logic [AW-1:0] a;
      w = 1'($urandom);
      a = $urandom_range(0, 3) == 0 ? AW'($urandom_range(0, 3)) : AW'($urandom);
      xfer(w, a, DW'($urandom), 3, $urandom_range(0, 2), 0, -1);
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
